// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_pkg;

  localparam int DIM_W_DEF = 12;
  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sobel_state_e;

  // APB register map of the config block feeding this controller
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_WIDTH   = 8'h04;
  localparam logic [7:0] ADDR_HEIGHT  = 8'h08;
  localparam logic [7:0] ADDR_TOTAL   = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;
  localparam logic [7:0] ADDR_IN_CNT  = 8'h14;
  localparam logic [7:0] ADDR_OUT_CNT = 8'h18;
  localparam logic [7:0] ADDR_ERR     = 8'h1C;
  localparam logic [7:0] ADDR_START   = 8'h20;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Pixel-stream and window handshake between the sequencer and the Sobel pipeline.
interface sobel_frame_ctrl_if
  import sobel_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
);
  logic             valid_in;
  logic             out_valid;
  logic             in_ready;
  logic             lb_wr_en;
  logic [DIM_W-1:0] pix_col;
  logic [DIM_W-1:0] pix_row;
  logic             win_valid;
  logic [DIM_W-1:0] win_col;
  logic [DIM_W-1:0] win_row;

  modport master (
    output valid_in, out_valid,
    input  in_ready, lb_wr_en, pix_col, pix_row, win_valid, win_col, win_row
  );

  modport slave (
    input  valid_in, out_valid,
    output in_ready, lb_wr_en, pix_col, pix_row, win_valid, win_col, win_row
  );
endinterface

// File: rtl/sobel_frame_ctrl_pos_counter.sv
// Row/column position counter; column wraps at width-1 and carries into row.
module sobel_pos_counter
  import sobel_pkg::*;
#(
  parameter int DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] width,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == width - DIM_W'(1)) begin
        col <= '0;
        row <= row + DIM_W'(1);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Sobel frame sequencer: geometry check, pixel gating, window-valid tracking, drain/timeout.
//   state | meaning
//   IDLE  | waiting for a start with valid geometry
//   RUN   | accepting input pixels, tracking row/column
//   DRAIN | input closed, counting datapath outputs under a watchdog
//   DONE  | frame complete (or timed out), sobel_done held high
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int DIM_W   = DIM_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIM_W-1:0]     cfg_width,
  input  logic [DIM_W-1:0]     cfg_height,
  input  logic [CNT_W-1:0]     cfg_total,
  input  logic                 start,
  input  logic                 abort,
  sobel_frame_ctrl_if.slave    pix,
  output logic                 busy,
  output logic                 sobel_done,
  output logic                 cfg_err,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int PX_W = 2 * DIM_W + CNT_W;

  sobel_state_e     state;
  logic [DIM_W-1:0] width_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] exp_q;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic [WD_W-1:0]  wdog;
  logic [PX_W-1:0]  prod_x;
  logic             geom_ok;
  logic             start_ok;
  logic             accept;
  logic             last_pix;
  logic             pos_clr;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             win_valid_q;
  logic [DIM_W-1:0] win_row_q;
  logic [DIM_W-1:0] win_col_q;

  // Product is computed wide enough that an overflowing geometry can never match total
  assign prod_x      = PX_W'(cfg_width) * PX_W'(cfg_height);
  assign geom_ok     = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3)) &&
                       (prod_x == PX_W'(cfg_total));
  assign start_ok    = start && !abort && ((state == IDLE) || (state == DONE)) && geom_ok;
  assign accept      = pix.valid_in && (state == RUN);
  assign last_pix    = (in_cnt == total_q - CNT_W'(1));
  assign pos_clr     = abort || start_ok;
  assign out_cnt_nxt = out_cnt + CNT_W'(pix.out_valid);

  assign pix.in_ready  = (state == RUN);
  assign pix.lb_wr_en  = accept;
  assign pix.pix_col   = col;
  assign pix.pix_row   = row;
  assign pix.win_valid = win_valid_q;
  assign pix.win_row   = win_row_q;
  assign pix.win_col   = win_col_q;
  assign busy          = (state == RUN) || (state == DRAIN);
  assign sobel_done    = (state == DONE);

  sobel_pos_counter #(.DIM_W(DIM_W)) u_pos (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (pos_clr),
    .en      (accept),
    .width   (width_q),
    .row     (row),
    .col     (col)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      width_q     <= '0;
      total_q     <= '0;
      exp_q       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wdog        <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      cfg_err     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      wdog        <= '0;
      win_valid_q <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (pix.valid_in && (state == DONE)) overrun <= 1'b1;
          if (start) begin
            if (geom_ok) begin
              width_q     <= cfg_width;
              total_q     <= cfg_total;
              exp_q       <= CNT_W'(cfg_height - DIM_W'(2)) * CNT_W'(cfg_width - DIM_W'(2));
              in_cnt      <= '0;
              out_cnt     <= '0;
              cfg_err     <= 1'b0;
              overrun     <= 1'b0;
              timeout_err <= 1'b0;
              state       <= RUN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          out_cnt <= out_cnt_nxt;
          if (accept) begin
            in_cnt <= in_cnt + CNT_W'(1);
            if ((row >= DIM_W'(2)) && (col >= DIM_W'(2))) begin
              win_valid_q <= 1'b1;
              win_row_q   <= row - DIM_W'(1);
              win_col_q   <= col - DIM_W'(1);
            end
            if (last_pix) begin
              state <= DRAIN;
              wdog  <= WD_W'(TIMEOUT - 1);
            end
          end
        end
        DRAIN: begin
          out_cnt <= out_cnt_nxt;
          if (pix.valid_in) overrun <= 1'b1;
          if (out_cnt_nxt >= exp_q) begin
            state <= DONE;
          end else if (pix.out_valid) begin
            wdog <= WD_W'(TIMEOUT - 1);
          end else if (wdog == '0) begin
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wdog <= wdog - WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: normal, gapped, overrun, timeout and abort frames.
module tb_sobel_frame_ctrl;
  import sobel_pkg::*;

  localparam int DW = 12;
  localparam int CW = 24;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] cfg_width;
  logic [DW-1:0] cfg_height;
  logic [CW-1:0] cfg_total;
  logic          start;
  logic          abort;
  logic          busy;
  logic          sobel_done;
  logic          cfg_err;
  logic          overrun;
  logic          timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int win_q[$];

  sobel_frame_ctrl_if #(.DIM_W(DW)) pix ();

  sobel_frame_ctrl #(.DIM_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_total   (cfg_total),
    .start       (start),
    .abort       (abort),
    .pix         (pix.slave),
    .busy        (busy),
    .sobel_done  (sobel_done),
    .cfg_err     (cfg_err),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (pix.win_valid === 1'b1) win_q.push_back(int'(pix.win_row) * 256 + int'(pix.win_col));

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_frame(input int total);
    cfg_width  = 5;
    cfg_height = 4;
    cfg_total  = CW'(total);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      pix.valid_in = 1'b1;
      #1;
      chk("lb_wr_en", 32'(pix.lb_wr_en), 1);
      chk("pix_row", 32'(pix.pix_row), 32'(i / 5));
      chk("pix_col", 32'(pix.pix_col), 32'(i % 5));
      tick();
      pix.valid_in = 1'b0;
      if (gap) tick();
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      pix.out_valid = 1'b1;
      tick();
      pix.out_valid = 1'b0;
      chk("done_after_ov", 32'(sobel_done), 32'(k == 5));
    end
  endtask

  task automatic check_wins();
    int expv;
    int obs;
    chk("win_count", 32'(win_q.size()), 6);
    for (int k = 0; k < 6; k++) begin
      expv = ((k < 3) ? 1 : 2) * 256 + (k % 3) + 1;
      obs  = (k < win_q.size()) ? win_q[k] : -1;
      chk("win_centre", 32'(obs), 32'(expv));
    end
    win_q.delete();
  endtask

  initial begin
    reset_n       = 1'b0;
    cfg_width     = '0;
    cfg_height    = '0;
    cfg_total     = '0;
    start         = 1'b0;
    abort         = 1'b0;
    pix.valid_in  = 1'b0;
    pix.out_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(pix.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(sobel_done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_win_valid", 32'(pix.win_valid), 0);
    chk("rst_pix_col", 32'(pix.pix_col), 0);
    reset_n = 1'b1;
    tick();

    // bad geometry, then good
    start_frame(21);
    chk("bad_cfg_err", 32'(cfg_err), 1);
    chk("bad_in_ready", 32'(pix.in_ready), 0);
    chk("bad_busy", 32'(busy), 0);
    start_frame(20);
    chk("good_cfg_err", 32'(cfg_err), 0);
    chk("good_in_ready", 32'(pix.in_ready), 1);
    chk("good_busy", 32'(busy), 1);

    // frame 1: consecutive pixels
    feed(20, 1'b0);
    chk("drain_in_ready", 32'(pix.in_ready), 0);
    chk("drain_busy", 32'(busy), 1);
    drain(6);
    chk("f1_busy", 32'(busy), 0);
    check_wins();

    // frame 2: gapped pixels, then overrun in DRAIN
    start_frame(20);
    chk("f2_done_clr", 32'(sobel_done), 0);
    feed(20, 1'b1);
    for (int j = 0; j < 4; j++) begin
      pix.valid_in = 1'b1;
      #1;
      chk("ovr_lb_wr_en", 32'(pix.lb_wr_en), 0);
      tick();
      pix.valid_in = 1'b0;
    end
    chk("overrun_set", 32'(overrun), 1);
    drain(6);
    chk("f2_overrun_kept", 32'(overrun), 1);
    check_wins();

    // frame 3: only 5 outputs, watchdog expires 16 cycles after the last one
    start_frame(20);
    chk("f3_overrun_clr", 32'(overrun), 0);
    feed(20, 1'b0);
    for (int k = 0; k < 5; k++) begin
      pix.out_valid = 1'b1;
      tick();
      pix.out_valid = 1'b0;
    end
    for (int t = 1; t <= TO; t++) begin
      tick();
      chk("to_done", 32'(sobel_done), 32'(t == TO));
    end
    chk("to_err", 32'(timeout_err), 1);
    chk("to_busy", 32'(busy), 0);
    win_q.delete();

    // frame 4: abort with start after 10 pixels, then a clean frame
    start_frame(20);
    chk("f4_to_clr", 32'(timeout_err), 0);
    feed(10, 1'b0);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_in_ready", 32'(pix.in_ready), 0);
    chk("abort_done", 32'(sobel_done), 0);
    chk("abort_win_valid", 32'(pix.win_valid), 0);
    chk("abort_pix_row", 32'(pix.pix_row), 0);
    chk("abort_pix_col", 32'(pix.pix_col), 0);
    win_q.delete();
    start_frame(20);
    chk("f5_busy", 32'(busy), 1);
    feed(20, 1'b0);
    drain(6);
    check_wins();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer for the Sobel datapath. It sits between the APB config registers and the pixel pipeline (line buffers, 3x3 window, gradient/threshold stage).
- Latches frame geometry on start and gates the input pixel stream.
- Tracks row/column of every accepted pixel and tells the window stage when a full 3x3 neighbourhood is available.
- Counts datapath outputs and raises sobel_done once the frame has drained; flags configuration, overrun and timeout errors.

Parameters:
DIM_W, 12, width of width/height/row/column fields (max dimension 4095)
CNT_W, 24, width of pixel counters and total-pixel field
TIMEOUT, 1024, max cycles allowed in DRAIN without an out_valid before timeout error

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_width  in  DIM_W  image width from APB reg 0x04
cfg_height  in  DIM_W  image height from APB reg 0x08
cfg_total  in  CNT_W  total pixels from APB reg 0x0C
start  in  1  one-cycle pulse from APB write of 1 to reg 0x20
abort  in  1  synchronous abort, highest priority
valid_in  in  1  input pixel valid (stream has no backpressure)
out_valid  in  1  datapath output pixel valid (valid_out of pipeline)
in_ready  out  1  controller accepting pixels (high only in RUN)
lb_wr_en  out  1  line-buffer write enable = valid_in & in_ready
pix_col  out  DIM_W  column of pixel being accepted this cycle
pix_row  out  DIM_W  row of pixel being accepted this cycle
win_valid  out  1  registered; 3x3 window centred on (win_row, win_col) is complete
win_col  out  DIM_W  centre column of valid window
win_row  out  DIM_W  centre row of valid window
busy  out  1  high in RUN or DRAIN
sobel_done  out  1  level, high in DONE until next accepted start, abort or reset
cfg_err  out  1  sticky: start rejected due to bad geometry
overrun  out  1  sticky: valid_in seen while not in RUN after a frame began
timeout_err  out  1  sticky: DRAIN watchdog expired

Behaviour:
- Reset: state IDLE, all outputs 0, counters 0, shadow config 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Geometry check: width>=3, height>=3, width*height == total (full CNT_W product; overflow counts as mismatch).
  - Pass: latch shadow config, clear counters and all sticky flags, sobel_done=0, go to RUN next cycle.
  - Fail: set cfg_err, stay in current state.
  - start in RUN/DRAIN is ignored.
- RUN:
  - in_ready=1. On valid_in, accept the pixel at (pix_row, pix_col).
  - Column increments; at width-1 it wraps to 0 and row increments. in_cnt increments.
  - If accepted pixel has row>=2 and col>=2: next cycle win_valid=1, win_row=row-1, win_col=col-1; else win_valid=0.
  - On accepting pixel in_cnt==total-1: go to DRAIN next cycle.
- DRAIN:
  - in_ready=0. Every out_valid (also counted in RUN) increments out_cnt.
  - When out_cnt reaches exp = (height-2)*(width-2): go to DONE next cycle.
  - Watchdog resets on each out_valid. If it reaches TIMEOUT: set timeout_err and go to DONE.
- DONE: sobel_done=1, busy=0. Remains until accepted start, abort or reset.
- valid_in outside RUN: pixel dropped, lb_wr_en=0. Sets overrun if state is DRAIN or DONE. No effect in IDLE.
- out_valid in IDLE: ignored.
- abort (any state): IDLE next cycle, counters cleared, sobel_done=0, win_valid=0. Sticky flags retained. Abort beats start in the same cycle.
- Mid-frame reset_n assertion: immediate return to reset values.
- Latency: lb_wr_en is combinational with valid_in. win_valid has 1 cycle latency. sobel_done rises 1 cycle after the final out_valid.

Decomposition:
- Package sobel_pkg: state enum (IDLE, RUN, DRAIN, DONE), APB address constants (0x00-0x20), default DIM_W/CNT_W.
- One sub-module: sobel_pos_counter (row/column counter with width wrap and enable), reusable by the output writer.

Test Plan:
- 5x4 frame (total 20), start, 20 consecutive valid_in -> 6 win_valid pulses with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3); DRAIN; 6 out_valid -> sobel_done=1 exactly 1 cycle after 6th.
- Start with width=5, height=4, total=21 -> cfg_err=1, state stays IDLE, in_ready=0; then start with total=20 -> cfg_err cleared, RUN.
- 5x4 frame with valid_in gaps (every other cycle) -> identical win_valid coordinate sequence; pix_col wraps 4->0 at each row end.
- 4 extra valid_in after 20th pixel -> lb_wr_en stays 0, overrun=1, done still asserted after 6 out_valid.
- TIMEOUT=16, only 5 out_valid delivered -> timeout_err=1 and sobel_done=1 16 cycles after 5th out_valid.
- abort asserted after 10 pixels, same cycle as start -> IDLE next cycle, busy=0, sobel_done=0; new start -> clean 20-pixel frame completes.
